// File: rtl/key_lut_pipe.sv
// ============================================================================
// key_lut_pipe : programmable key/data table with registered valid/ready lookup
// Revision     : 1.0
// ============================================================================
`default_nettype none

module key_lut_pipe #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter bit HAS_DEFAULT = 1'b1,
  parameter bit PRIORITY    = 1'b1,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                inv_en,
  input  logic [IDX_W-1:0]    inv_idx,
  input  logic                flush,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  logic [NR_KEY-1:0]   valid_q;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [NR_KEY-1:0]   match;

  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic [DATA_LEN-1:0] lk_pri_data;
  logic [DATA_LEN-1:0] lk_or_data;
  logic [DATA_LEN-1:0] lk_data;
  logic                accept;

  // Each entry owns its storage; a write to the same index outranks invalidate.
  for (genvar i = 0; i < NR_KEY; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[i] <= 1'b0;
        key_q[i]   <= '0;
        data_q[i]  <= '0;
      end else if (flush) begin
        valid_q[i] <= 1'b0;
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        valid_q[i] <= 1'b1;
        key_q[i]   <= wr_key;
        data_q[i]  <= wr_data;
      end else if (inv_en && (inv_idx == IDX_W'(i))) begin
        valid_q[i] <= 1'b0;
      end
    end

    assign match[i] = valid_q[i] && (key_q[i] == req_key);
  end

  always_comb begin
    lk_hit      = |match;
    lk_idx      = '0;
    lk_pri_data = '0;
    lk_or_data  = '0;
    // Descending scan so the lowest matching index is the last one assigned.
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (match[i]) begin
        lk_idx      = IDX_W'(i);
        lk_pri_data = data_q[i];
        lk_or_data  = lk_or_data | data_q[i];
      end
    end
    if (lk_hit) begin
      lk_data = PRIORITY ? lk_pri_data : lk_or_data;
    end else begin
      lk_data = HAS_DEFAULT ? default_out : '0;
    end
  end

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= lk_data;
      rsp_hit   <= lk_hit;
      rsp_idx   <= lk_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (lk_hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (!lk_hit && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_lut_pipe.sv
// ============================================================================
// tb_key_lut_pipe : directed bench, one default DUT and one OR-merge/no-default/CNT_W=2 DUT
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_key_lut_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, inv_en, flush, req_valid, rsp_ready;
  logic [1:0] wr_idx, inv_idx;
  logic [3:0] wr_key, req_key;
  logic [7:0] wr_data, default_out;

  logic        req_ready0, rsp_valid0, rsp_hit0;
  logic [7:0]  rsp_data0;
  logic [1:0]  rsp_idx0;
  logic [15:0] hit_cnt0, miss_cnt0;

  logic        req_ready1, rsp_valid1, rsp_hit1;
  logic [7:0]  rsp_data1;
  logic [1:0]  rsp_idx1;
  logic [1:0]  hit_cnt1, miss_cnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_lut_pipe #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b1),
                 .PRIORITY(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .inv_en(inv_en), .inv_idx(inv_idx), .flush(flush),
    .default_out(default_out), .req_valid(req_valid), .req_ready(req_ready0),
    .req_key(req_key), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data0), .rsp_hit(rsp_hit0), .rsp_idx(rsp_idx0),
    .hit_cnt(hit_cnt0), .miss_cnt(miss_cnt0));

  key_lut_pipe #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b0),
                 .PRIORITY(1'b0), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .inv_en(inv_en), .inv_idx(inv_idx), .flush(flush),
    .default_out(default_out), .req_valid(req_valid), .req_ready(req_ready1),
    .req_key(req_key), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data1), .rsp_hit(rsp_hit1), .rsp_idx(rsp_idx1),
    .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0; req_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] key, input logic [7:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_data = data;
  endtask

  task automatic lookup(input logic [3:0] key);
    req_valid = 1'b1; req_key = key;
  endtask

  initial begin
    rst_n = 1'b0; idle(); rsp_ready = 1'b1;
    wr_idx = '0; inv_idx = '0; wr_key = '0; wr_data = '0; req_key = '0;
    default_out = 8'hAA;
    #3;
    check("reset_req_ready", {req_ready1, req_ready0}, 2'b11);
    check("reset_rsp_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    check("reset_cnt0", {hit_cnt0, miss_cnt0}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Empty table: miss returns default (dut0) or zero (dut1)
    lookup(4'h3); step(); idle();
    check("miss_valid", {rsp_valid1, rsp_valid0}, 2'b11);
    check("miss_hit_idx", {rsp_hit0, rsp_idx0, rsp_hit1, rsp_idx1}, 6'b0);
    check("miss_data0", rsp_data0, 8'hAA);
    check("miss_data1", rsp_data1, 8'h00);
    check("miss_cnt_first", {miss_cnt1, miss_cnt0}, {2'd1, 16'd1});

    // Lookup in the same cycle as the write does not see it
    wr(2'd2, 4'h5, 8'h3C); lookup(4'h5); step(); idle();
    check("same_cycle_wr_miss", rsp_hit0, 1'b0);
    check("same_cycle_miss_cnt0", miss_cnt0, 16'd2);

    lookup(4'h5); step(); idle();
    check("hit_idx2", {rsp_hit0, rsp_idx0, rsp_hit1, rsp_idx1}, {1'b1, 2'd2, 1'b1, 2'd2});
    check("hit_data", {rsp_data1, rsp_data0}, 16'h3C3C);
    check("hit_cnt_first", {hit_cnt1, hit_cnt0}, {2'd1, 16'd1});

    // Two entries share key 7: priority vs OR merge
    wr(2'd1, 4'h7, 8'h0F); step();
    wr(2'd3, 4'h7, 8'hF0); step(); idle();
    lookup(4'h7); step(); idle();
    check("multi_idx", {rsp_idx1, rsp_idx0}, {2'd1, 2'd1});
    check("multi_data_pri", rsp_data0, 8'h0F);
    check("multi_data_or", rsp_data1, 8'hFF);
    check("multi_hit_cnt", {hit_cnt1, hit_cnt0}, {2'd2, 16'd2});

    // Retire with no new request keeps the payload
    step();
    check("retire_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    check("retire_data_kept", rsp_data0, 8'h0F);

    // Stall: accept one, then hold with consumer not ready
    rsp_ready = 1'b0;
    lookup(4'h5); step();
    check("stall_first_data", rsp_data0, 8'h3C);
    check("stall_cnt_sat", {hit_cnt1, hit_cnt0}, {2'd3, 16'd3});
    req_key = 4'h7;
    wr(2'd2, 4'h5, 8'h55);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_req_ready", {req_ready1, req_ready0}, 2'b00);
      step();
      wr_en = 1'b0;
      check("stall_rsp_hold", {rsp_valid0, rsp_hit0, rsp_idx0, rsp_data0}, {1'b1, 1'b1, 2'd2, 8'h3C});
      check("stall_cnt_hold", hit_cnt0, 16'd3);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_req_ready", req_ready0, 1'b1);
    step();
    check("b2b_first", {rsp_valid0, rsp_idx0, rsp_data0}, {1'b1, 2'd1, 8'h0F});
    lookup(4'h5); step(); idle();
    check("b2b_second", {rsp_valid0, rsp_idx0, rsp_data0}, {1'b1, 2'd2, 8'h55});
    check("b2b_hit_cnt", {hit_cnt1, hit_cnt0}, {2'd3, 16'd5});

    // flush overrides a concurrent write
    flush = 1'b1; wr(2'd0, 4'h9, 8'h99); step(); idle();
    lookup(4'h9); step(); idle();
    check("flush_wr_miss", {rsp_hit1, rsp_hit0}, 2'b00);
    check("flush_miss_data0", rsp_data0, 8'hAA);
    lookup(4'h7); step(); idle();
    check("flush_cleared", rsp_hit0, 1'b0);
    check("miss_cnt_sat", {miss_cnt1, miss_cnt0}, {2'd3, 16'd4});

    // Write beats invalidate on the same index
    wr(2'd0, 4'h4, 8'h44); inv_en = 1'b1; inv_idx = 2'd0; step(); idle();
    lookup(4'h4); step(); idle();
    check("wr_inv_same", {rsp_hit0, rsp_idx0, rsp_data0}, {1'b1, 2'd0, 8'h44});

    // Different indices: both applied
    wr(2'd1, 4'h6, 8'h66); inv_en = 1'b1; inv_idx = 2'd0; step(); idle();
    lookup(4'h4); step(); idle();
    check("wr_inv_diff_inv", rsp_hit0, 1'b0);
    lookup(4'h6); step(); idle();
    check("wr_inv_diff_wr", {rsp_hit0, rsp_idx0, rsp_data0}, {1'b1, 2'd1, 8'h66});

    // Reset while a response is pending
    rsp_ready = 1'b0;
    lookup(4'h6); step(); idle();
    check("pre_reset_valid", rsp_valid0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    check("async_rst_cnt", {hit_cnt1, miss_cnt1, hit_cnt0, miss_cnt0}, 36'h0);
    check("async_rst_ready", {req_ready1, req_ready0}, 2'b11);
    step();
    rst_n = 1'b1; rsp_ready = 1'b1;
    step();
    lookup(4'h6); step(); idle();
    check("post_rst_empty", {rsp_valid0, rsp_hit0, rsp_hit1}, 3'b100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
